// File: rtl/wave_capture_reader_pkg.sv
// Shared definitions for the scope-trace path: capture FSM encoding, screen geometry
// and the sample-to-row mapping used by the hit compare.
package wave_capture_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } cap_state_e;

  localparam int DEPTH = 640;
  localparam int COL_W = 10;
  localparam int Y_MAX = 479;

  // Top 9 bits of a sample map to a row; large values clip to the top of the screen.
  function automatic logic [COL_W-1:0] y_of_s9(input logic [8:0] s9);
    if (int'(s9) > Y_MAX) begin
      return '0;
    end
    return COL_W'(Y_MAX - int'(s9));
  endfunction

endpackage

// File: rtl/wave_ram.sv
// Simple dual-port trace buffer: one write port, one registered read port.
// A same-address read and write returns the previously stored word.
module wave_ram #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 12,
  parameter int AW     = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/wave_capture_reader.sv
// Captures one screen-width of trigger-aligned samples and serves them back by pixel
// column, with a per-pixel hit flag for drawing the trace.
module wave_capture_reader
  import wave_capture_reader_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int TRIG_LVL = 2048,
  parameter int AUTO_TO  = 4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              frame_start,
  input  logic              freeze,
  input  logic [COL_W-1:0]  pix_x,
  input  logic [COL_W-1:0]  pix_y,
  input  logic              pix_valid,
  output logic [DATA_W-1:0] rd_sample,
  output logic              rd_hit,
  output logic              rd_valid,
  output logic              capturing,
  output logic              trace_ready
);

  localparam int AUTO_W = $clog2(AUTO_TO);

  cap_state_e         state_q, state_d;
  logic [COL_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AUTO_W-1:0]  auto_cnt_q, auto_cnt_d;
  logic [DATA_W-1:0]  prev_q;
  logic               rd_valid_q;
  logic               rd_in_range_q;
  logic [COL_W-1:0]   pix_y_q;

  logic               ram_we;
  logic [COL_W-1:0]   ram_wr_addr;
  logic [DATA_W-1:0]  ram_rd_data;
  logic               rd_in_range;
  logic [COL_W-1:0]   ram_rd_addr;
  logic               trig;

  assign trig = ((prev_q < DATA_W'(TRIG_LVL)) && (sample_in >= DATA_W'(TRIG_LVL)))
             || (auto_cnt_q == AUTO_W'(AUTO_TO - 1));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    auto_cnt_d  = auto_cnt_q;
    ram_we      = 1'b0;
    ram_wr_addr = wr_ptr_q;
    case (state_q)
      IDLE: state_d = ARMED;
      ARMED: begin
        if (sample_valid) begin
          if (trig) begin
            ram_we      = 1'b1;
            ram_wr_addr = '0;
            wr_ptr_d    = COL_W'(1);
            state_d     = CAPTURE;
          end else if (auto_cnt_q < AUTO_W'(AUTO_TO - 1)) begin
            auto_cnt_d = auto_cnt_q + AUTO_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          ram_we = 1'b1;
          if (wr_ptr_q == COL_W'(DEPTH - 1)) begin
            wr_ptr_d = '0;
            state_d  = HOLD;
          end else begin
            wr_ptr_d = wr_ptr_q + COL_W'(1);
          end
        end
      end
      HOLD: begin
        if (frame_start && !freeze) begin
          auto_cnt_d = '0;
          state_d    = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // prev tracks every sample regardless of state so a crossing is judged on true history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      auto_cnt_q <= '0;
      prev_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      auto_cnt_q <= auto_cnt_d;
      if (sample_valid) begin
        prev_q <= sample_in;
      end
    end
  end

  assign rd_in_range = (pix_x < COL_W'(DEPTH));
  assign ram_rd_addr = rd_in_range ? pix_x : '0;

  wave_ram #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .AW    (COL_W)
  ) u_ram (
    .clk_i    (clk),
    .we_i     (ram_we),
    .wr_addr_i(ram_wr_addr),
    .wr_data_i(sample_in),
    .rd_addr_i(ram_rd_addr),
    .rd_data_o(ram_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q    <= 1'b0;
      rd_in_range_q <= 1'b0;
      pix_y_q       <= '0;
    end else begin
      rd_valid_q    <= pix_valid;
      rd_in_range_q <= rd_in_range;
      pix_y_q       <= pix_y;
    end
  end

  // The RAM read register has no reset; the range flag masks it to zero instead.
  assign rd_sample   = rd_in_range_q ? ram_rd_data : '0;
  assign rd_hit      = rd_valid_q && rd_in_range_q
                    && (pix_y_q == y_of_s9(rd_sample[DATA_W-1 -: 9]));
  assign rd_valid    = rd_valid_q;
  assign capturing   = (state_q == CAPTURE);
  assign trace_ready = (state_q == HOLD);

endmodule

// File: tb/tb_wave_capture_reader.sv
// Directed bench for wave_capture_reader: ramp trigger, auto trigger, freeze/hold,
// column readback with hit mapping, read/write collision and mid-capture reset.
module tb_wave_capture_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        frame_start;
  logic        freeze;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid;
  logic [11:0] rd_sample;
  logic        rd_hit;
  logic        rd_valid;
  logic        capturing;
  logic        trace_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wave_capture_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .frame_start (frame_start),
    .freeze      (freeze),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .rd_sample   (rd_sample),
    .rd_hit      (rd_hit),
    .rd_valid    (rd_valid),
    .capturing   (capturing),
    .trace_ready (trace_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] val, input int gap);
    sample_in    = val;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (gap - 1) step();
  endtask

  function automatic int yModel(input int s);
    int s9;
    s9 = s / 8;
    return (s9 > 479) ? 0 : 479 - s9;
  endfunction

  task automatic readCol(input int x, input int y);
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; frame_start = 1'b0;
    freeze = 1'b0; pix_x = '0; pix_y = '0; pix_valid = 1'b0;
    repeat (3) step();
    checkOutput("reset_capturing", 32'(capturing), 0);
    checkOutput("reset_trace_ready", 32'(trace_ready), 0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 0);
    checkOutput("reset_rd_hit", 32'(rd_hit), 0);
    checkOutput("reset_rd_sample", 32'(rd_sample), 0);

    rst_n = 1'b1;
    repeat (2) step();

    // Ramp capture: trigger on the 2047 -> 2048 crossing
    for (int v = 2000; v < 2048; v++) applyStimulus(12'(v), 4);
    checkOutput("ramp_pre_trigger", 32'(capturing), 0);
    sample_in = 12'd2048; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    checkOutput("ramp_trigger", 32'(capturing), 1);
    repeat (3) step();
    for (int v = 2049; v < 2687; v++) applyStimulus(12'(v), 4);
    checkOutput("ramp_not_done_ready", 32'(trace_ready), 0);
    checkOutput("ramp_not_done_cap", 32'(capturing), 1);
    sample_in = 12'd2687; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    checkOutput("ramp_done_ready", 32'(trace_ready), 1);
    checkOutput("ramp_done_cap", 32'(capturing), 0);

    for (int i = 0; i < 640; i++) begin
      pix_x     = 10'(i);
      pix_y     = 10'(yModel(2048 + i) + (i % 2));
      pix_valid = 1'b1;
      step();
      checkOutput("ramp_read_sample", 32'(rd_sample), 32'(2048 + i));
      checkOutput("ramp_read_valid", 32'(rd_valid), 1);
      checkOutput("ramp_read_hit", 32'(rd_hit), 32'((i % 2) == 0));
    end
    pix_valid = 1'b0;
    readCol(0, 223);
    checkOutput("hit_2048_row223", 32'(rd_hit), 1);
    readCol(639, 0);
    checkOutput("mem639", 32'(rd_sample), 2687);
    readCol(700, 223);
    checkOutput("oob_sample", 32'(rd_sample), 0);
    checkOutput("oob_hit", 32'(rd_hit), 0);
    checkOutput("oob_valid", 32'(rd_valid), 1);
    pix_x = 10'd0; pix_y = 10'd223;
    step();
    checkOutput("novalid_rd_valid", 32'(rd_valid), 0);
    checkOutput("novalid_rd_hit", 32'(rd_hit), 0);

    // Freeze holds the trace across frames
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      frame_start = 1'b1; step();
      frame_start = 1'b0; step();
      checkOutput("freeze_hold", 32'(trace_ready), 1);
    end
    applyStimulus(12'd100, 2);
    checkOutput("hold_sample_stays", 32'(trace_ready), 1);
    freeze = 1'b0;
    frame_start = 1'b1; sample_in = 12'd3000; sample_valid = 1'b1;
    step();
    frame_start = 1'b0; sample_valid = 1'b0;
    checkOutput("leave_hold_ready", 32'(trace_ready), 0);
    checkOutput("leave_hold_cap", 32'(capturing), 0);
    repeat (2) step();
    checkOutput("leave_sample_no_trig", 32'(capturing), 0);

    // Auto trigger on the 4000th ARMED sample
    for (int n = 1; n < 4000; n++) applyStimulus(12'd100, 1);
    checkOutput("auto_pre", 32'(capturing), 0);
    applyStimulus(12'd100, 1);
    checkOutput("auto_trigger", 32'(capturing), 1);
    applyStimulus(12'd0, 1);
    applyStimulus(12'd4095, 1);
    for (int i = 3; i < 640; i++) begin
      if (i == 300) freeze = 1'b1;
      applyStimulus(12'd100, 1);
    end
    checkOutput("auto_cap_done_frozen", 32'(trace_ready), 1);
    readCol(1, 479);
    checkOutput("hit0_sample", 32'(rd_sample), 0);
    checkOutput("hit0_row479", 32'(rd_hit), 1);
    readCol(2, 0);
    checkOutput("hit4095_sample", 32'(rd_sample), 4095);
    checkOutput("hit4095_row0", 32'(rd_hit), 1);
    readCol(2, 1);
    checkOutput("hit4095_row1", 32'(rd_hit), 0);
    readCol(0, yModel(100));
    checkOutput("auto_addr0", 32'(rd_sample), 100);
    checkOutput("auto_addr0_hit", 32'(rd_hit), 1);
    frame_start = 1'b1; step();
    frame_start = 1'b0;
    checkOutput("frozen_again", 32'(trace_ready), 1);
    freeze = 1'b0;
    frame_start = 1'b1; step();
    frame_start = 1'b0;
    checkOutput("rearm", 32'(trace_ready), 0);

    // Collision: reading the address being written returns the old word
    applyStimulus(12'd2500, 1);
    checkOutput("coll_trigger", 32'(capturing), 1);
    for (int i = 1; i < 5; i++) applyStimulus(12'(2500 + i), 1);
    pix_x = 10'd5; pix_valid = 1'b1;
    applyStimulus(12'd2505, 1);
    pix_valid = 1'b0;
    checkOutput("collision_old", 32'(rd_sample), 100);
    readCol(5, 0);
    checkOutput("collision_new", 32'(rd_sample), 2505);
    for (int i = 6; i < 300; i++) applyStimulus(12'(2500 + i), 1);
    pix_x = 10'd5; pix_valid = 1'b1;
    step();
    checkOutput("pre_reset_cap", 32'(capturing), 1);
    checkOutput("pre_reset_valid", 32'(rd_valid), 1);
    sample_in = 12'd2800; sample_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_cap", 32'(capturing), 0);
    checkOutput("async_reset_ready", 32'(trace_ready), 0);
    checkOutput("async_reset_valid", 32'(rd_valid), 0);
    checkOutput("async_reset_hit", 32'(rd_hit), 0);
    checkOutput("async_reset_sample", 32'(rd_sample), 0);
    sample_valid = 1'b0; pix_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    checkOutput("post_reset_cap", 32'(capturing), 0);
    checkOutput("post_reset_ready", 32'(trace_ready), 0);

    applyStimulus(12'd2048, 1);
    checkOutput("restart_trigger", 32'(capturing), 1);
    for (int i = 1; i < 640; i++) applyStimulus(12'((i * 37) % 4096), 1);
    checkOutput("restart_done", 32'(trace_ready), 1);
    readCol(0, 223);
    checkOutput("restart_addr0", 32'(rd_sample), 2048);
    checkOutput("restart_addr0_hit", 32'(rd_hit), 1);
    readCol(1, 0);
    checkOutput("restart_addr1", 32'(rd_sample), 37);
    readCol(300, yModel((300 * 37) % 4096));
    checkOutput("restart_addr300", 32'(rd_sample), 32'((300 * 37) % 4096));
    checkOutput("restart_addr300_hit", 32'(rd_hit), 1);
    readCol(639, 0);
    checkOutput("restart_addr639", 32'(rd_sample), 32'((639 * 37) % 4096));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
